// File: rtl/boot_pkg.sv
// Shared boot-path definitions: UART receive state encoding, line levels and
// bit-period arithmetic that a future transmitter can reuse.
package boot_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } uart_rx_state_t;

  localparam logic UART_STOP_LEVEL = 1'b1;

  // Clock cycles per serial bit, rounded to nearest.
  function automatic int unsigned uart_bit_cycles(input int unsigned clk_frequency,
                                                  input int unsigned baud_rate);
    return (clk_frequency + baud_rate / 2) / baud_rate;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer with a parameterized reset value, for bringing
// asynchronous boot inputs into the clk domain.
module sync_2ff #(
  parameter int unsigned           WIDTH       = 1,
  parameter logic [WIDTH-1:0]      RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= RESET_VALUE;
      sync_q <= RESET_VALUE;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/boot_uart_receiver.sv
// 8N1 UART receiver for the boot loader: mid-bit sampling of the synchronized
// RX line, one-cycle out_valid per good character, framing errors dropped.
module boot_uart_receiver
  import boot_pkg::*;
#(
  parameter int unsigned clk_frequency = 50 * 1000 * 1000,
  parameter int unsigned baud_rate     = 115200,
  parameter int unsigned char_width    = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rx,
  output logic                  out_valid,
  output logic [char_width-1:0] out_char,
  output logic                  framing_error,
  output logic                  busy
);

  localparam int unsigned BIT_CYCLES  = uart_bit_cycles(clk_frequency, baud_rate);
  localparam int unsigned HALF_CYCLES = BIT_CYCLES / 2;
  localparam int unsigned TW          = $clog2(BIT_CYCLES);
  localparam int unsigned IW          = $clog2(char_width + 1);

  localparam logic [TW-1:0] BIT_RELOAD  = TW'(BIT_CYCLES - 1);
  localparam logic [TW-1:0] HALF_RELOAD = TW'(HALF_CYCLES - 1);
  localparam logic [IW-1:0] LAST_INDEX  = IW'(char_width - 1);

  if (BIT_CYCLES < 4) begin : g_bad_baud
    $error("boot_uart_receiver: fewer than 4 clock cycles per bit");
  end

  logic rx_s;

  sync_2ff #(
    .WIDTH      (1),
    .RESET_VALUE(1'b1)
  ) u_rx_sync (
    .clk(clk),
    .rst(reset),
    .d  (rx),
    .q  (rx_s)
  );

  uart_rx_state_t        state_q, state_d;
  logic [TW-1:0]         bit_timer_q, bit_timer_d;
  logic [IW-1:0]         bit_index_q, bit_index_d;
  logic [char_width-1:0] shift_reg_q, shift_reg_d;
  logic [char_width-1:0] out_char_q, out_char_d;
  logic                  out_valid_q, out_valid_d;
  logic                  framing_error_q, framing_error_d;

  wire timer_done = (bit_timer_q == '0);

  always_comb begin
    state_d         = state_q;
    bit_timer_d     = bit_timer_q;
    bit_index_d     = bit_index_q;
    shift_reg_d     = shift_reg_q;
    out_char_d      = out_char_q;
    out_valid_d     = 1'b0;
    framing_error_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!rx_s) begin
          bit_timer_d = HALF_RELOAD;
          state_d     = START;
        end
      end

      START: begin
        if (!timer_done) begin
          bit_timer_d = bit_timer_q - TW'(1);
        end else if (rx_s) begin
          state_d = IDLE;
        end else begin
          bit_timer_d = BIT_RELOAD;
          bit_index_d = '0;
          state_d     = DATA;
        end
      end

      DATA: begin
        if (!timer_done) begin
          bit_timer_d = bit_timer_q - TW'(1);
        end else begin
          // LSB arrives first, so shifting in at the MSB leaves bit 0 in place.
          shift_reg_d = {rx_s, shift_reg_q[char_width-1:1]};
          bit_index_d = bit_index_q + IW'(1);
          bit_timer_d = BIT_RELOAD;
          if (bit_index_q == LAST_INDEX) begin
            state_d = STOP;
          end
        end
      end

      STOP: begin
        if (!timer_done) begin
          bit_timer_d = bit_timer_q - TW'(1);
        end else if (rx_s == UART_STOP_LEVEL) begin
          out_char_d  = shift_reg_q;
          out_valid_d = 1'b1;
          state_d     = IDLE;
        end else begin
          framing_error_d = 1'b1;
          state_d         = WAIT_HIGH;
        end
      end

      WAIT_HIGH: begin
        if (rx_s) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= IDLE;
      bit_timer_q     <= '0;
      bit_index_q     <= '0;
      shift_reg_q     <= '0;
      out_char_q      <= '0;
      out_valid_q     <= 1'b0;
      framing_error_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      bit_timer_q     <= bit_timer_d;
      bit_index_q     <= bit_index_d;
      shift_reg_q     <= shift_reg_d;
      out_char_q      <= out_char_d;
      out_valid_q     <= out_valid_d;
      framing_error_q <= framing_error_d;
    end
  end

  // The result pulse lands in the first IDLE cycle, so it extends busy.
  assign busy          = (state_q != IDLE) || out_valid_q || framing_error_q;
  assign out_valid     = out_valid_q;
  assign out_char      = out_char_q;
  assign framing_error = framing_error_q;

endmodule

// File: tb/tb_boot_uart_receiver.sv
// Directed bench for boot_uart_receiver at 16 clocks per bit.
module tb_boot_uart_receiver;

  localparam int unsigned BITC = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx = 1'b1;
  logic       out_valid;
  logic       framing_error;
  logic       busy;
  logic [7:0] out_char;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  int         vcyc[$];
  logic [7:0] vch[$];
  int         fe_cnt = 0;
  logic       prev_pulse = 1'b0;

  boot_uart_receiver #(
    .clk_frequency(16),
    .baud_rate    (1),
    .char_width   (8)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .rx           (rx),
    .out_valid    (out_valid),
    .out_char     (out_char),
    .framing_error(framing_error),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (out_valid) begin
      vcyc.push_back(cyc);
      vch.push_back(out_char);
    end
    if (framing_error) fe_cnt++;
    if (out_valid || framing_error) begin
      chk("pulse_exclusive", {31'b0, out_valid & framing_error}, 32'd0);
      chk("pulse_not_consecutive", {31'b0, prev_pulse}, 32'd0);
    end
    prev_pulse = out_valid | framing_error;
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called just after a posedge; leaves rx at the stop level.
  task automatic send(input logic [7:0] ch, input logic stop_level, output int fall);
    rx = 1'b0;
    fall = cyc;
    idle(BITC);
    for (int i = 0; i < 8; i++) begin
      rx = ch[i];
      idle(BITC);
    end
    rx = stop_level;
    idle(BITC);
  endtask

  initial begin
    int f, f2, base, fbase;
    logic [7:0] stream [10];
    logic [31:0] word;
    int digits, words;

    stream = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h0D, 8'h0A};

    // Reset state
    idle(3);
    @(negedge clk);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_framing_error", {31'b0, framing_error}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_out_char", {24'b0, out_char}, 32'h00);
    @(posedge clk); #1;
    reset = 1'b0;
    idle(5);

    // Single frame 'A': pulse 155 cycles after the pin falls (T0 + 153)
    base = vch.size();
    send(8'h41, 1'b1, f);
    idle(4);
    chk("a_count", vch.size(), base + 1);
    chk("a_cycle", vcyc[base], f + 155);
    chk("a_char", {24'b0, vch[base]}, 32'h41);
    chk("a_no_ferr", fe_cnt, 0);
    chk("a_busy_low", {31'b0, busy}, 32'd0);

    // Back-to-back CR LF
    base = vch.size();
    send(8'h0D, 1'b1, f);
    send(8'h0A, 1'b1, f2);
    idle(4);
    chk("b2b_count", vch.size(), base + 2);
    chk("b2b_spacing", vcyc[base + 1] - vcyc[base], 160);
    chk("b2b_char0", {24'b0, vch[base]}, 32'h0D);
    chk("b2b_char1", {24'b0, vch[base + 1]}, 32'h0A);
    chk("b2b_hold_char", {24'b0, out_char}, 32'h0A);

    // 3-cycle glitch
    base = vch.size();
    rx = 1'b0;
    idle(3);
    rx = 1'b1;
    idle(1);
    @(negedge clk);
    chk("glitch_busy_high", {31'b0, busy}, 32'd1);
    idle(10);
    @(negedge clk);
    chk("glitch_busy_low", {31'b0, busy}, 32'd0);
    chk("glitch_no_valid", vch.size(), base);
    chk("glitch_no_ferr", fe_cnt, 0);

    // Framing error then a held-low break
    base = vch.size();
    send(8'h55, 1'b0, f);
    idle(50);
    @(negedge clk);
    chk("ferr_count", fe_cnt, 1);
    chk("ferr_no_valid", vch.size(), base);
    chk("ferr_char_kept", {24'b0, out_char}, 32'h0A);
    chk("ferr_busy_waithigh", {31'b0, busy}, 32'd1);
    rx = 1'b1;
    idle(5);
    @(negedge clk);
    chk("ferr_busy_released", {31'b0, busy}, 32'd0);
    send(8'h31, 1'b1, f);
    idle(4);
    chk("after_ferr_count", vch.size(), base + 1);
    chk("after_ferr_char", {24'b0, out_char}, 32'h31);
    chk("after_ferr_single_ferr", fe_cnt, 1);

    // Reset after data bit 4 of 0xA5
    base = vch.size();
    fbase = fe_cnt;
    rx = 1'b0;
    idle(BITC);
    for (int i = 0; i < 4; i++) begin
      rx = (8'hA5 >> i) & 8'h01;
      idle(BITC);
    end
    @(negedge clk);
    chk("midframe_busy", {31'b0, busy}, 32'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    rx = 1'b1;
    idle(3);
    @(negedge clk);
    chk("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("mid_rst_framing_error", {31'b0, framing_error}, 32'd0);
    chk("mid_rst_busy", {31'b0, busy}, 32'd0);
    chk("mid_rst_out_char", {24'b0, out_char}, 32'h00);
    @(posedge clk); #1;
    reset = 1'b0;
    idle(5);
    send(8'h3C, 1'b1, f);
    idle(4);
    chk("post_rst_count", vch.size(), base + 1);
    chk("post_rst_char", {24'b0, out_char}, 32'h3C);
    chk("post_rst_no_ferr", fe_cnt, fbase);

    // "12345678\r\n" through a hex-word accumulation model
    base = vch.size();
    for (int i = 0; i < 10; i++) begin
      send(stream[i], 1'b1, f);
    end
    idle(4);
    chk("stream_count", vch.size(), base + 10);
    word = '0;
    digits = 0;
    words = 0;
    for (int i = 0; i < 10; i++) begin
      chk("stream_char", {24'b0, vch[base + i]}, {24'b0, stream[i]});
      if (vch[base + i] >= 8'h30 && vch[base + i] <= 8'h39) begin
        word = {word[27:0], 4'(vch[base + i] - 8'h30)};
        digits++;
      end else if (vch[base + i] == 8'h0D || vch[base + i] == 8'h0A) begin
        if (digits > 0) begin
          words++;
          chk("stream_word", word, 32'h12345678);
        end
        digits = 0;
        word = '0;
      end
    end
    chk("stream_words", words, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/boot_uart_receiver.md
# boot_uart_receiver

Serial receiver for the boot loader path: it samples the asynchronous UART RX pin and recovers 8N1 characters. Each character is presented as a one-cycle `out_valid` pulse with `out_char`. The block sits directly upstream of the boot hex parser: `out_valid`/`out_char` connect to its `in_valid`/`in_char`. Framing errors are flagged and the character is dropped, never forwarded.

## Interface
- `clk_frequency`, 50 * 1000 * 1000, clock frequency in Hz.
- `baud_rate`, 115200, serial bit rate.
- `char_width`, 8, data bits per frame, sent LSB first.
- `clk`  input  1  system clock; the block uses this single clock only.
- `reset`  input  1  asynchronous, active-high reset.
- `rx`  input  1  raw UART line; asynchronous to `clk`; idle high.
- `out_valid`  output  1  one-cycle pulse when a good character is received.
- `out_char`  output  char_width  received character; held until the next good frame.
- `framing_error`  output  1  one-cycle pulse when the stop bit samples 0.
- `busy`  output  1  high whenever the state is not IDLE.

## Operation
- Derived constants:
  - `bit_cycles = (clk_frequency + baud_rate / 2) / baud_rate`, i.e. rounded to nearest.
  - `half_cycles = bit_cycles / 2`.
  - Elaboration fails (`$error`) if `bit_cycles < 4`.
- `rx` passes through a two-flop synchronizer that resets to 1. All logic below uses the synchronized value `rx_s`.
- Down-counter `bit_timer`, width `$clog2(bit_cycles)`. Bit counter `bit_index`, width `$clog2(char_width + 1)`.
- State machine:
  - IDLE: when `rx_s == 0`, load `bit_timer = half_cycles - 1` and go to START.
  - START: when `bit_timer == 0`, sample `rx_s`.
    - Sample 1: glitch; go back to IDLE with no output.
    - Sample 0: load `bit_timer = bit_cycles - 1`, set `bit_index = 0`, go to DATA.
  - DATA: when `bit_timer == 0`, shift `rx_s` into the MSB of `shift_reg` (right shift) and increment `bit_index`.
    - After the `char_width`-th bit, go to STOP.
    - Otherwise reload `bit_timer = bit_cycles - 1`.
    - On the last bit, also reload `bit_timer` so STOP starts a full bit period.
  - STOP: when `bit_timer == 0`, sample `rx_s`.
    - Sample 1: `out_char <= shift_reg`, pulse `out_valid`, go to IDLE.
    - Sample 0: pulse `framing_error`, leave `out_char` unchanged, go to WAIT_HIGH.
  - WAIT_HIGH: stay until `rx_s == 1`, then go to IDLE. A held-low break line therefore produces exactly one `framing_error`.
- `out_valid` and `framing_error` are never high together and never high for two consecutive cycles.
- No parity. No receive FIFO: the downstream stage must accept one character per cycle, which the hex parser does.

## Timing
- Reset values: `out_valid = 0`, `framing_error = 0`, `busy = 0`, `out_char = 0`, state IDLE, synchronizer = 1.
- Reset is honoured mid-frame. The partial character is discarded and the next falling edge after reset release starts a fresh frame.
- Let T0 be the first cycle in which IDLE sees `rx_s == 0`. This is 2–3 cycles after the pin falls.
- Sample points:
  - Start bit: T0 + `half_cycles`.
  - Data bit k (k = 1..`char_width`): T0 + `half_cycles` + k * `bit_cycles`.
  - Stop bit: T0 + `half_cycles` + (`char_width` + 1) * `bit_cycles`.
- `out_valid` / `framing_error` are registered and are high in the cycle after the stop sample.
- Back-to-back frames: IDLE is entered in the cycle after the stop sample. A start bit that immediately follows the stop bit is detected, because the stop sample is taken mid-bit. Tolerates about ±4% total baud mismatch.
- `busy` is high from T0 + 1 through the cycle of the result pulse, and through all of WAIT_HIGH.

## Structure
- Shared package `boot_pkg`:
  - state enum `uart_rx_state_t` (IDLE, START, DATA, STOP, WAIT_HIGH);
  - constant `UART_STOP_LEVEL = 1'b1`;
  - function `uart_bit_cycles(clk_frequency, baud_rate)`, reused by a future transmitter.
- One sub-module: `sync_2ff`, a parameterized reset-value two-flop synchronizer, reusable for other async boot inputs.
- Remaining RTL is the FSM plus counters, about 150 lines.

## Test plan
Bench uses `clk_frequency = 16`, `baud_rate = 1`, so `bit_cycles = 16` and `half_cycles = 8`.

- Send frame 0x41 ("A") -> exactly one `out_valid` at T0 + 8 + 9*16 + 1 = T0 + 153, `out_char == 8'h41`, no `framing_error`.
- Back-to-back 0x0D, 0x0A with a single stop bit each -> two `out_valid` pulses 160 cycles apart, `out_char` 8'h0D then 8'h0A.
- `rx` low for 3 cycles only -> no `out_valid`, no `framing_error`, `busy` returns low within 10 cycles.
- Frame 0x55 with stop bit driven 0, then line held low for 50 cycles -> one `framing_error` pulse, `out_char` keeps its previous value. The next good frame 0x31 yields `out_char == 8'h31`.
- Assert `reset` after data bit 4 of frame 0xA5 -> outputs return to reset values. The following frame 0x3C yields exactly one `out_valid` with `out_char == 8'h3C`.
- Stream "12345678\r\n" into the hex parser -> 10 `out_valid` pulses in order, and the parser emits one word 0x12345678.
